mc_cu: RTL and testbench

Multicycle control unit for the MIPS-subset CPU. It replaces the single-cycle decoder with a 5-state FSM: IF, ID, EXE, MEM, WB. It drives the shared-memory datapath (one memory, IR, A/B/C/D holding registers, one ALU) and adds an optional memory wait handshake with a timeout. It decodes the same 21-instruction subset as the single-cycle unit, including `gt` (R-type, func 000001).

---
 rtl/mc_cu.sv | 198 +++++++++++++++++++
 tb/tb_mc_cu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// Multicycle control unit for the MIPS-subset CPU: a 5-state IF/ID/EXE/MEM/WB
// sequencer with an optional memory-ready handshake and a sticky wait timeout.
module mc_cu #(
    parameter bit WAIT_EN  = 1'b0,
    parameter int TO_LIMIT = 15,
    parameter int TO_W     = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       jal,
    output logic       sext,
    output logic       ill,
    output logic       tmo,
    output logic [2:0] state
);

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WB  = 3'b100;

    logic [2:0]      r_state, w_next;
    logic [TO_W-1:0] r_cnt;
    logic            r_tmo;

    logic w_r, w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra, w_jr, w_gt;
    logic w_addi, w_andi, w_ori, w_xori, w_lw, w_sw, w_beq, w_bne, w_lui, w_j, w_jal;
    logic w_alu_r, w_imm, w_shift, w_sext, w_itype, w_jump, w_legal;
    logic [3:0] w_aluc;
    logic w_go, w_waiting, w_to;
    logic w_wpc, w_wir, w_wmem, w_wreg;

    assign w_r    = (op == 6'b000000);
    assign w_add  = w_r & (func == 6'b100000);
    assign w_sub  = w_r & (func == 6'b100010);
    assign w_and  = w_r & (func == 6'b100100);
    assign w_or   = w_r & (func == 6'b100101);
    assign w_xor  = w_r & (func == 6'b100110);
    assign w_sll  = w_r & (func == 6'b000000);
    assign w_srl  = w_r & (func == 6'b000010);
    assign w_sra  = w_r & (func == 6'b000011);
    assign w_jr   = w_r & (func == 6'b001000);
    assign w_gt   = w_r & (func == 6'b000001);
    assign w_addi = (op == 6'b001000);
    assign w_andi = (op == 6'b001100);
    assign w_ori  = (op == 6'b001101);
    assign w_xori = (op == 6'b001110);
    assign w_lw   = (op == 6'b100011);
    assign w_sw   = (op == 6'b101011);
    assign w_beq  = (op == 6'b000100);
    assign w_bne  = (op == 6'b000101);
    assign w_lui  = (op == 6'b001111);
    assign w_j    = (op == 6'b000010);
    assign w_jal  = (op == 6'b000011);

    assign w_shift = w_sll | w_srl | w_sra;
    assign w_alu_r = w_add | w_sub | w_and | w_or | w_xor | w_shift | w_gt;
    assign w_imm   = w_addi | w_andi | w_ori | w_xori | w_lui;
    assign w_itype = w_imm | w_lw;
    assign w_sext  = w_addi | w_lw | w_sw | w_beq | w_bne;
    assign w_jump  = w_j | w_jal | w_jr;
    assign w_legal = w_alu_r | w_imm | w_lw | w_sw | w_beq | w_bne | w_jump;

    always_comb begin
        w_aluc = 4'b0000;
        if (w_sub | w_beq | w_bne)  w_aluc = 4'b0100;
        else if (w_and | w_andi)    w_aluc = 4'b0001;
        else if (w_or | w_ori)      w_aluc = 4'b0101;
        else if (w_xor | w_xori)    w_aluc = 4'b0010;
        else if (w_lui)             w_aluc = 4'b0110;
        else if (w_sll)             w_aluc = 4'b0011;
        else if (w_srl)             w_aluc = 4'b0111;
        else if (w_sra)             w_aluc = 4'b1111;
        else if (w_gt)              w_aluc = 4'b1011;
    end

    // Timeout fires on the wait cycle that would bring the count to TO_LIMIT.
    assign w_go      = mready | ~WAIT_EN;
    assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !w_go;
    assign w_to      = w_waiting && (r_cnt == TO_W'(TO_LIMIT - 1));

    always_comb begin
        w_next   = r_state;
        w_wpc    = 1'b0;
        w_wir    = 1'b0;
        w_wmem   = 1'b0;
        w_wreg   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        aluc     = 4'b0000;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        jal      = 1'b0;
        sext     = 1'b0;
        ill      = 1'b0;
        case (r_state)
            S_IF: begin
                alusrcb = 2'b01;
                w_wpc   = w_go;
                w_wir   = w_go;
                if (w_go) w_next = S_ID;
            end
            S_ID: begin
                if (!w_legal) begin
                    ill    = 1'b1;
                    w_next = S_IF;
                end else if (w_jump) begin
                    w_wpc    = 1'b1;
                    pcsource = w_jr ? 2'b10 : 2'b11;
                    w_wreg   = w_jal;
                    jal      = w_jal;
                    w_next   = S_IF;
                end else begin
                    // Branch target PC+4+(imm<<2) is parked in C for EXE.
                    alusrcb = 2'b11;
                    sext    = w_sext;
                    w_next  = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                aluc    = w_aluc;
                alusrcb = (w_imm | w_lw | w_sw) ? 2'b10 : 2'b00;
                shift   = w_shift;
                sext    = w_sext;
                if (w_beq | w_bne) begin
                    pcsource = 2'b01;
                    w_wpc    = (w_beq & z) | (w_bne & ~z);
                    w_next   = S_IF;
                end else if (w_lw | w_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                w_wmem = w_sw & w_go;
                if (w_go) w_next = w_sw ? S_IF : S_WB;
            end
            S_WB: begin
                w_wreg = 1'b1;
                regrt  = w_itype;
                m2reg  = w_lw;
                w_next = S_IF;
            end
            default: w_next = S_IF;
        endcase
        if (w_to) begin
            w_wpc  = 1'b0;
            w_wir  = 1'b0;
            w_wmem = 1'b0;
            w_next = S_IF;
        end
    end

    // Strobes are gated by the reset pin so nothing is written while held.
    assign wpc   = w_wpc & clrn;
    assign wir   = w_wir & clrn;
    assign wmem  = w_wmem & clrn;
    assign wreg  = w_wreg & clrn;
    assign tmo   = r_tmo;
    assign state = r_state;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IF;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_to) r_tmo <= 1'b1;
            if (w_to || (w_next != r_state)) r_cnt <= '0;
            else if (w_waiting)              r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu: a no-wait instance driven from a vector table and
// a wait/timeout instance driven by hand-written multi-cycle sequences.
module tb_mc_cu;

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WB  = 3'b100;

    typedef struct packed {
        logic [2:0] state;
        logic wpc, wir, wmem, wreg, iord, regrt, m2reg;
        logic [3:0] aluc;
        logic shift, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic jal, sext, ill, tmo;
    } ctl_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        ctl_t       e;
    } vec_t;

    logic clk, clrn, z, mr_nw, mr_w;
    logic [5:0] op, func;

    logic wpc0, wir0, wmem0, wreg0, iord0, regrt0, m2reg0, shift0, alusrca0, jal0, sext0, ill0, tmo0;
    logic wpc1, wir1, wmem1, wreg1, iord1, regrt1, m2reg1, shift1, alusrca1, jal1, sext1, ill1, tmo1;
    logic [3:0] aluc0, aluc1;
    logic [1:0] alusrcb0, alusrcb1, pcsource0, pcsource1;
    logic [2:0] st0, st1;
    ctl_t c0, c1;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    mc_cu #(.WAIT_EN(1'b0), .TO_LIMIT(15), .TO_W(4)) u_nw (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mready(mr_nw),
        .wpc(wpc0), .wir(wir0), .wmem(wmem0), .wreg(wreg0), .iord(iord0),
        .regrt(regrt0), .m2reg(m2reg0), .aluc(aluc0), .shift(shift0),
        .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsource(pcsource0),
        .jal(jal0), .sext(sext0), .ill(ill0), .tmo(tmo0), .state(st0)
    );

    mc_cu #(.WAIT_EN(1'b1), .TO_LIMIT(3), .TO_W(4)) u_w (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mready(mr_w),
        .wpc(wpc1), .wir(wir1), .wmem(wmem1), .wreg(wreg1), .iord(iord1),
        .regrt(regrt1), .m2reg(m2reg1), .aluc(aluc1), .shift(shift1),
        .alusrca(alusrca1), .alusrcb(alusrcb1), .pcsource(pcsource1),
        .jal(jal1), .sext(sext1), .ill(ill1), .tmo(tmo1), .state(st1)
    );

    assign c0 = {st0, wpc0, wir0, wmem0, wreg0, iord0, regrt0, m2reg0, aluc0, shift0,
                 alusrca0, alusrcb0, pcsource0, jal0, sext0, ill0, tmo0};
    assign c1 = {st1, wpc1, wir1, wmem1, wreg1, iord1, regrt1, m2reg1, aluc1, shift1,
                 alusrca1, alusrcb1, pcsource1, jal1, sext1, ill1, tmo1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t f_if(input logic go);
        ctl_t c = '0;
        c.state = S_IF; c.alusrcb = 2'b01; c.wpc = go; c.wir = go;
        return c;
    endfunction

    function automatic ctl_t f_id(input logic sx);
        ctl_t c = '0;
        c.state = S_ID; c.alusrcb = 2'b11; c.sext = sx;
        return c;
    endfunction

    function automatic ctl_t f_exe(input logic [3:0] al, input logic [1:0] sb, input logic sh, input logic sx);
        ctl_t c = '0;
        c.state = S_EXE; c.alusrca = 1'b1; c.aluc = al; c.alusrcb = sb; c.shift = sh; c.sext = sx;
        return c;
    endfunction

    function automatic ctl_t f_br(input logic take);
        ctl_t c = f_exe(4'b0100, 2'b00, 1'b0, 1'b1);
        c.pcsource = 2'b01; c.wpc = take;
        return c;
    endfunction

    function automatic ctl_t f_mem(input logic wm);
        ctl_t c = '0;
        c.state = S_MEM; c.iord = 1'b1; c.wmem = wm;
        return c;
    endfunction

    function automatic ctl_t f_wb(input logic rt, input logic m2);
        ctl_t c = '0;
        c.state = S_WB; c.wreg = 1'b1; c.regrt = rt; c.m2reg = m2;
        return c;
    endfunction

    function automatic ctl_t f_jmp(input logic [1:0] ps, input logic jl);
        ctl_t c = '0;
        c.state = S_ID; c.wpc = 1'b1; c.pcsource = ps; c.wreg = jl; c.jal = jl;
        return c;
    endfunction

    function automatic ctl_t f_ill();
        ctl_t c = '0;
        c.state = S_ID; c.ill = 1'b1;
        return c;
    endfunction

    function automatic ctl_t f_t(input ctl_t c);
        ctl_t r = c;
        r.tmo = 1'b1;
        return r;
    endfunction

    // sext is only meaningful while the extender feeds the ALU (ID/EXE).
    task automatic chk(input string nm, input ctl_t g, input ctl_t e);
        ctl_t gm = g;
        if (e.state != S_ID && e.state != S_EXE) gm.sext = e.sext;
        checks++;
        if (gm !== e) begin
            errors++;
            $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                     nm, g.state, g, e.state, e);
        end
    endtask

    task automatic at(input string nm, input ctl_t e, input bit w);
        #1;
        chk(nm, w ? c1 : c0, e);
        @(negedge clk);
    endtask

    task automatic tv(input string nm, input logic [5:0] o, input logic [5:0] f, input logic zz, input ctl_t e);
        vec_t v;
        v.nm = nm; v.op = o; v.func = f; v.z = zz; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic rt(input string nm, input logic [5:0] f, input logic [3:0] al, input logic sh);
        tv({nm, "_if"}, 6'b000000, f, 1'b0, f_if(1'b1));
        tv({nm, "_id"}, 6'b000000, f, 1'b0, f_id(1'b0));
        tv({nm, "_exe"}, 6'b000000, f, 1'b0, f_exe(al, 2'b00, sh, 1'b0));
        tv({nm, "_wb"}, 6'b000000, f, 1'b0, f_wb(1'b0, 1'b0));
    endtask

    task automatic it(input string nm, input logic [5:0] o, input logic [3:0] al, input logic sx);
        tv({nm, "_if"}, o, 6'b111111, 1'b0, f_if(1'b1));
        tv({nm, "_id"}, o, 6'b111111, 1'b0, f_id(sx));
        tv({nm, "_exe"}, o, 6'b111111, 1'b0, f_exe(al, 2'b10, 1'b0, sx));
        tv({nm, "_wb"}, o, 6'b111111, 1'b0, f_wb(1'b1, 1'b0));
    endtask

    task automatic br(input string nm, input logic [5:0] o, input logic zz, input logic take);
        tv({nm, "_if"}, o, 6'b000000, zz, f_if(1'b1));
        tv({nm, "_id"}, o, 6'b000000, zz, f_id(1'b1));
        tv({nm, "_exe"}, o, 6'b000000, zz, f_br(take));
    endtask

    initial begin
        clrn = 1'b0; op = 6'b000000; func = 6'b100000; z = 1'b0;
        mr_nw = 1'b0; mr_w = 1'b1;

        rt("add", 6'b100000, 4'b0000, 1'b0);
        rt("sub", 6'b100010, 4'b0100, 1'b0);
        rt("and", 6'b100100, 4'b0001, 1'b0);
        rt("or",  6'b100101, 4'b0101, 1'b0);
        rt("xor", 6'b100110, 4'b0010, 1'b0);
        rt("sll", 6'b000000, 4'b0011, 1'b1);
        rt("srl", 6'b000010, 4'b0111, 1'b1);
        rt("sra", 6'b000011, 4'b1111, 1'b1);
        rt("gt",  6'b000001, 4'b1011, 1'b0);
        it("addi", 6'b001000, 4'b0000, 1'b1);
        it("andi", 6'b001100, 4'b0001, 1'b0);
        it("ori",  6'b001101, 4'b0101, 1'b0);
        it("xori", 6'b001110, 4'b0010, 1'b0);
        it("lui",  6'b001111, 4'b0110, 1'b0);
        br("beq_z1", 6'b000100, 1'b1, 1'b1);
        br("beq_z0", 6'b000100, 1'b0, 1'b0);
        br("bne_z0", 6'b000101, 1'b0, 1'b1);
        br("bne_z1", 6'b000101, 1'b1, 1'b0);
        tv("sw_if",  6'b101011, 6'b0, 1'b0, f_if(1'b1));
        tv("sw_id",  6'b101011, 6'b0, 1'b0, f_id(1'b1));
        tv("sw_exe", 6'b101011, 6'b0, 1'b0, f_exe(4'b0000, 2'b10, 1'b0, 1'b1));
        tv("sw_mem", 6'b101011, 6'b0, 1'b0, f_mem(1'b1));
        tv("lw_if",  6'b100011, 6'b0, 1'b0, f_if(1'b1));
        tv("lw_id",  6'b100011, 6'b0, 1'b0, f_id(1'b1));
        tv("lw_exe", 6'b100011, 6'b0, 1'b0, f_exe(4'b0000, 2'b10, 1'b0, 1'b1));
        tv("lw_mem", 6'b100011, 6'b0, 1'b0, f_mem(1'b0));
        tv("lw_wb",  6'b100011, 6'b0, 1'b0, f_wb(1'b1, 1'b1));
        tv("jal_if", 6'b000011, 6'b0, 1'b0, f_if(1'b1));
        tv("jal_id", 6'b000011, 6'b0, 1'b0, f_jmp(2'b11, 1'b1));
        tv("j_if",   6'b000010, 6'b0, 1'b0, f_if(1'b1));
        tv("j_id",   6'b000010, 6'b0, 1'b0, f_jmp(2'b11, 1'b0));
        tv("jr_if",  6'b000000, 6'b001000, 1'b0, f_if(1'b1));
        tv("jr_id",  6'b000000, 6'b001000, 1'b0, f_jmp(2'b10, 1'b0));
        tv("ill_if", 6'b111111, 6'b0, 1'b0, f_if(1'b1));
        tv("ill_id", 6'b111111, 6'b0, 1'b0, f_ill());
        tv("illr_if", 6'b000000, 6'b111111, 1'b0, f_if(1'b1));
        tv("illr_id", 6'b000000, 6'b111111, 1'b0, f_ill());
        tv("ill_end", 6'b000000, 6'b111111, 1'b0, f_if(1'b1));

        // Reset held for three cycles: IF decode with every strobe low.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_w", c1, f_if(1'b0));
            at("rst_nw", f_if(1'b0), 1'b0);
        end
        clrn = 1'b1;
        at("rel_if", f_if(1'b1), 1'b0);
        at("rel_id", f_id(1'b0), 1'b0);

        // Reset mid-instruction: the pending WB write must not appear.
        at("ab_exe", f_exe(4'b0000, 2'b00, 1'b0, 1'b0), 1'b0);
        clrn = 1'b0;
        at("ab_rst", f_if(1'b0), 1'b0);
        clrn = 1'b1;
        at("ab_rel", f_if(1'b1), 1'b0);
        clrn = 1'b0; @(negedge clk); clrn = 1'b1;

        foreach (tbl[i]) begin
            op = tbl[i].op; func = tbl[i].func; z = tbl[i].z;
            at(tbl[i].nm, tbl[i].e, 1'b0);
        end

        // lw with IF and MEM waits on the handshake instance.
        clrn = 1'b0; @(negedge clk); clrn = 1'b1;
        op = 6'b100011; func = 6'b0; z = 1'b0; mr_w = 1'b0;
        at("wlw_ifw", f_if(1'b0), 1'b1);
        mr_w = 1'b1;
        at("wlw_if", f_if(1'b1), 1'b1);
        mr_w = 1'b0;
        at("wlw_id", f_id(1'b1), 1'b1);
        at("wlw_exe", f_exe(4'b0000, 2'b10, 1'b0, 1'b1), 1'b1);
        at("wlw_mem0", f_mem(1'b0), 1'b1);
        at("wlw_mem1", f_mem(1'b0), 1'b1);
        mr_w = 1'b1;
        at("wlw_mem2", f_mem(1'b0), 1'b1);
        mr_w = 1'b0;
        at("wlw_wb", f_wb(1'b1, 1'b1), 1'b1);
        at("wlw_back", f_if(1'b0), 1'b1);

        // sw with mready stuck low: timeout after three MEM cycles, no write.
        op = 6'b101011; mr_w = 1'b1;
        at("wsw_if", f_if(1'b1), 1'b1);
        mr_w = 1'b0;
        at("wsw_id", f_id(1'b1), 1'b1);
        at("wsw_exe", f_exe(4'b0000, 2'b10, 1'b0, 1'b1), 1'b1);
        at("wsw_mem0", f_mem(1'b0), 1'b1);
        at("wsw_mem1", f_mem(1'b0), 1'b1);
        at("wsw_mem2", f_mem(1'b0), 1'b1);
        at("wsw_to_if", f_t(f_if(1'b0)), 1'b1);
        at("wif_w1", f_t(f_if(1'b0)), 1'b1);
        at("wif_w2", f_t(f_if(1'b0)), 1'b1);
        at("wif_w3", f_t(f_if(1'b0)), 1'b1);
        mr_w = 1'b1;
        at("wif_go", f_t(f_if(1'b1)), 1'b1);
        at("wif_id", f_t(f_id(1'b1)), 1'b1);
        clrn = 1'b0;
        at("wtmo_clr", f_if(1'b0), 1'b1);
        clrn = 1'b1;
        at("wtmo_rel", f_if(1'b1), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
